light_sequencer: RTL and testbench

//  Sequences one signal head through GREEN->YELLOW->RED by driving the phase down-counter's one-hot init/en controls and consuming its last flag.

---
 rtl/light_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_light_sequencer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/light_sequencer.sv
// light_sequencer: drives one signal head through GREEN -> YELLOW -> RED by
// steering an external phase down-counter (one-hot load select + enable) and
// reacting to its "last" flag. A flashing-yellow maintenance mode is entered
// via flash_req.
// Optional build macro PED_REQ_EN adds a pedestrian request input that can cut
// green short once a minimum green time has elapsed, plus a walk output that
// is lit for the whole RED phase.
module light_sequencer #(
    parameter int pCNT_WIDTH      = 5,
    parameter int pINIT_WIDTH     = 3,
    parameter int pGREEN_INIT_VAL = 14,
    parameter int pPED_MIN_GREEN  = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   tick,
    input  logic                   run,
    input  logic                   flash_req,
    input  logic                   cnt_last,
    input  logic [pCNT_WIDTH-1:0]  cnt_value,
`ifdef PED_REQ_EN
    input  logic                   ped_req,
    output logic                   ped_walk,
`endif
    output logic [pINIT_WIDTH-1:0] cnt_init,
    output logic                   cnt_en,
    output logic                   lamp_g,
    output logic                   lamp_y,
    output logic                   lamp_r,
    output logic [1:0]             phase
);

    typedef enum logic [2:0] {
        ST_START,
        ST_GREEN,
        ST_YELLOW,
        ST_RED,
        ST_FLASH
    } state_t;

    // One-hot counter load selects
    localparam logic [pINIT_WIDTH-1:0] INIT_NONE   = '0;
    localparam logic [pINIT_WIDTH-1:0] INIT_GREEN  = pINIT_WIDTH'(1);
    localparam logic [pINIT_WIDTH-1:0] INIT_YELLOW = pINIT_WIDTH'(2);
    localparam logic [pINIT_WIDTH-1:0] INIT_RED    = pINIT_WIDTH'(4);

    state_t state_reg;
    state_t state_next;
    logic   flash_toggle;   // lamp_y flips on this step while staying in FLASH
    logic   ped_force;      // pedestrian request is allowed to end green now

`ifdef PED_REQ_EN
    // Counter value at or below which enough green has elapsed
    localparam logic [pCNT_WIDTH-1:0] PED_THRESH =
        pCNT_WIDTH'(pGREEN_INIT_VAL - pPED_MIN_GREEN);

    logic ped_pending_reg;

    assign ped_force = ped_pending_reg && (cnt_value <= PED_THRESH);
`else
    // Without the pedestrian feature the counter value and green-timing
    // parameters have no consumer; fold them into a sink so they stay visible.
    localparam int unused_ped_thresh = pGREEN_INIT_VAL - pPED_MIN_GREEN;
    logic unused_cnt_value;

    assign unused_cnt_value = ^cnt_value;
    assign ped_force        = 1'b0;
`endif

    // Next-state decode and counter controls; everything is quiet while
    // frozen (run=0) or held in reset.
    always_comb begin
        state_next   = state_reg;
        cnt_init     = INIT_NONE;
        cnt_en       = 1'b0;
        flash_toggle = 1'b0;
        if (!rst && run) begin
            case (state_reg)
                ST_START: begin
                    // Leaving START does not wait for a tick
                    cnt_init   = INIT_GREEN;
                    cnt_en     = 1'b1;
                    state_next = ST_GREEN;
                end
                ST_GREEN: begin
                    if (tick) begin
                        cnt_en = 1'b1;
                        // Green always hands over to yellow, whatever the cause
                        if (flash_req || ped_force || cnt_last) begin
                            cnt_init   = INIT_YELLOW;
                            state_next = ST_YELLOW;
                        end
                    end
                end
                ST_YELLOW: begin
                    if (tick) begin
                        if (cnt_last) begin
                            if (flash_req) begin
                                state_next = ST_FLASH;
                            end else begin
                                cnt_init   = INIT_RED;
                                cnt_en     = 1'b1;
                                state_next = ST_RED;
                            end
                        end else begin
                            cnt_en = 1'b1;
                        end
                    end
                end
                ST_RED: begin
                    if (tick) begin
                        // flash_req outranks the end-of-phase flag
                        if (flash_req) begin
                            state_next = ST_FLASH;
                        end else if (cnt_last) begin
                            cnt_init   = INIT_GREEN;
                            cnt_en     = 1'b1;
                            state_next = ST_GREEN;
                        end else begin
                            cnt_en = 1'b1;
                        end
                    end
                end
                ST_FLASH: begin
                    if (tick) begin
                        if (!flash_req) begin
                            cnt_init   = INIT_RED;
                            cnt_en     = 1'b1;
                            state_next = ST_RED;
                        end else begin
                            flash_toggle = 1'b1;
                        end
                    end
                end
                default: state_next = ST_START;
            endcase
        end
    end

    // State register with lamps and phase registered from the next state so
    // they change on the same edge as the state itself.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_START;
            lamp_g    <= 1'b0;
            lamp_y    <= 1'b0;
            lamp_r    <= 1'b1;
            phase     <= 2'b00;
        end else begin
            state_reg <= state_next;
            case (state_next)
                ST_GREEN: begin
                    lamp_g <= 1'b1;
                    lamp_y <= 1'b0;
                    lamp_r <= 1'b0;
                    phase  <= 2'b01;
                end
                ST_YELLOW: begin
                    lamp_g <= 1'b0;
                    lamp_y <= 1'b1;
                    lamp_r <= 1'b0;
                    phase  <= 2'b10;
                end
                ST_RED: begin
                    lamp_g <= 1'b0;
                    lamp_y <= 1'b0;
                    lamp_r <= 1'b1;
                    phase  <= 2'b11;
                end
                ST_FLASH: begin
                    lamp_g <= 1'b0;
                    lamp_r <= 1'b0;
                    // Yellow is lit on entry, then flips once per step
                    lamp_y <= (state_reg == ST_FLASH) ? (lamp_y ^ flash_toggle) : 1'b1;
                    phase  <= 2'b11;
                end
                default: begin
                    lamp_g <= 1'b0;
                    lamp_y <= 1'b0;
                    lamp_r <= 1'b1;
                    phase  <= 2'b00;
                end
            endcase
        end
    end

`ifdef PED_REQ_EN
    // Pedestrian request latch (a new request beats the clear on RED entry)
    // and walk indication that tracks the RED phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ped_pending_reg <= 1'b0;
            ped_walk        <= 1'b0;
        end else begin
            if (ped_req) begin
                ped_pending_reg <= 1'b1;
            end else if (state_next == ST_RED && state_reg != ST_RED) begin
                ped_pending_reg <= 1'b0;
            end
            ped_walk <= (state_next == ST_RED);
        end
    end
`endif

endmodule

// File: tb/tb_light_sequencer.sv
// Directed bench for light_sequencer. A small behavioural phase counter
// (GREEN 14, YELLOW 2, RED 17, reset to GREEN) closes the loop around the DUT.
// Ticks arrive every 10 clocks; inputs change on the falling edge and outputs
// are sampled on the falling edge.
module tb_light_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic       run;
    logic       flash_req;
    logic       cnt_last;
    logic [4:0] cnt_value;
    logic [2:0] cnt_init;
    logic       cnt_en;
    logic       lamp_g;
    logic       lamp_y;
    logic       lamp_r;
    logic [1:0] phase;
`ifdef PED_REQ_EN
    logic       ped_req;
    logic       ped_walk;
`endif

    int checks = 0;
    int errors = 0;

    light_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .run       (run),
        .flash_req (flash_req),
        .cnt_last  (cnt_last),
        .cnt_value (cnt_value),
`ifdef PED_REQ_EN
        .ped_req   (ped_req),
        .ped_walk  (ped_walk),
`endif
        .cnt_init  (cnt_init),
        .cnt_en    (cnt_en),
        .lamp_g    (lamp_g),
        .lamp_y    (lamp_y),
        .lamp_r    (lamp_r),
        .phase     (phase)
    );

    always #5 clk = ~clk;

    // Behavioural phase down-counter driven by the DUT's controls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_value <= 5'd14;
        end else if (cnt_en) begin
            if (cnt_init == 3'b001)      cnt_value <= 5'd14;
            else if (cnt_init == 3'b010) cnt_value <= 5'd2;
            else if (cnt_init == 3'b100) cnt_value <= 5'd17;
            else                         cnt_value <= cnt_value - 5'd1;
        end
    end
    assign cnt_last = (cnt_value == 5'd0);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // {lamp_g, lamp_y, lamp_r, phase}
    task automatic check_lamps(input string tag, input logic [4:0] exp);
        check(tag, {27'd0, lamp_g, lamp_y, lamp_r, phase}, {27'd0, exp});
    endtask

    // {cnt_init, cnt_en}
    task automatic check_ctl(input string tag, input logic [3:0] exp);
        check(tag, {28'd0, cnt_init, cnt_en}, {28'd0, exp});
    endtask

    task automatic tick_begin();
        @(negedge clk);
        tick = 1'b1;
        #1;
    endtask

    task automatic tick_end();
        @(negedge clk);
        tick = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            tick_begin();
            tick_end();
        end
    endtask

    localparam logic [4:0] L_START = 5'b001_00;
    localparam logic [4:0] L_GREEN = 5'b100_01;
    localparam logic [4:0] L_YEL   = 5'b010_10;
    localparam logic [4:0] L_RED   = 5'b001_11;
    localparam logic [4:0] L_FY1   = 5'b010_11;
    localparam logic [4:0] L_FY0   = 5'b000_11;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        run       = 1'b0;
        tick      = 1'b0;
        flash_req = 1'b0;
`ifdef PED_REQ_EN
        ped_req   = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check_lamps("reset_lamps", L_START);
        check_ctl("reset_ctl", 4'b000_0);

        // Start: first run cycle loads GREEN without a tick
        @(negedge clk);
        rst = 1'b0;
        run = 1'b1;
        #1;
        check_ctl("start_ctl", 4'b001_1);
        @(negedge clk);
        check_lamps("start_green", L_GREEN);
        check("start_value", {27'd0, cnt_value}, 32'd14);

        // Full cycle: G15 / Y3 / R18
        ticks(14);
        check_lamps("green_14", L_GREEN);
        tick_begin();
        check_ctl("g2y_ctl", 4'b010_1);
        tick_end();
        check_lamps("yellow_entry", L_YEL);
        ticks(2);
        check_lamps("yellow_3", L_YEL);
        tick_begin();
        check_ctl("y2r_ctl", 4'b100_1);
        tick_end();
        check_lamps("red_entry", L_RED);
        ticks(17);
        check_lamps("red_18", L_RED);
        tick_begin();
        check_ctl("r2g_ctl", 4'b001_1);
        tick_end();
        check_lamps("green_again", L_GREEN);

        // Freeze mid-green at value 9 for 7 ticks
        ticks(5);
        check("freeze_value_before", {27'd0, cnt_value}, 32'd9);
        run = 1'b0;
        repeat (7) begin
            tick_begin();
            check_ctl("freeze_ctl", 4'b000_0);
            tick_end();
        end
        check("freeze_value_after", {27'd0, cnt_value}, 32'd9);
        check_lamps("freeze_lamps", L_GREEN);
        run = 1'b1;
        ticks(9);
        check_lamps("resume_green_9", L_GREEN);
        ticks(1);
        check_lamps("resume_yellow_10", L_YEL);
        ticks(3);
        ticks(18);
        check_lamps("cycle_green", L_GREEN);

        // Flash request at green value 10
        ticks(4);
        check("flash_value", {27'd0, cnt_value}, 32'd10);
        flash_req = 1'b1;
        tick_begin();
        check_ctl("flash_g2y_ctl", 4'b010_1);
        tick_end();
        check_lamps("flash_yellow", L_YEL);
        ticks(2);
        check_lamps("flash_yellow_end", L_YEL);
        tick_begin();
        check_ctl("y2flash_ctl", 4'b000_0);
        tick_end();
        check_lamps("flash_on_1", L_FY1);
        ticks(1);
        check_lamps("flash_off", L_FY0);
        ticks(1);
        check_lamps("flash_on_2", L_FY1);
        flash_req = 1'b0;
        tick_begin();
        check_ctl("flash_exit_ctl", 4'b100_1);
        tick_end();
        check_lamps("flash_exit_red", L_RED);
        check("flash_exit_value", {27'd0, cnt_value}, 32'd17);

        // flash_req together with cnt_last in RED
        ticks(17);
        check("red_last_value", {27'd0, cnt_value}, 32'd0);
        flash_req = 1'b1;
        tick_begin();
        check_ctl("red_last_flash_ctl", 4'b000_0);
        tick_end();
        check_lamps("red_last_flash", L_FY1);
        flash_req = 1'b0;
        ticks(1);
        check_lamps("flash_to_red", L_RED);
        ticks(18);
        ticks(15);
        check_lamps("pre_reset_yellow", L_YEL);
        ticks(1);

        // Reset pulse mid-yellow
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_lamps("midrst_lamps", L_START);
        check_ctl("midrst_ctl", 4'b000_0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_ctl("restart_ctl", 4'b001_1);
        @(negedge clk);
        check_lamps("restart_green", L_GREEN);

`ifdef PED_REQ_EN
        // Pedestrian request at green value 13
        ticks(1);
        check("ped_value", {27'd0, cnt_value}, 32'd13);
        ped_req = 1'b1;
        @(negedge clk);
        ped_req = 1'b0;
        ticks(4);
        check_lamps("ped_green_9", L_GREEN);
        check("ped_value_9", {27'd0, cnt_value}, 32'd9);
        tick_begin();
        check_ctl("ped_g2y_ctl", 4'b010_1);
        tick_end();
        check_lamps("ped_yellow", L_YEL);
        check("ped_walk_yellow", {31'd0, ped_walk}, 32'd0);
        ticks(3);
        check_lamps("ped_red", L_RED);
        check("ped_walk_red_start", {31'd0, ped_walk}, 32'd1);
        ticks(17);
        check("ped_walk_red_end", {31'd0, ped_walk}, 32'd1);
        ticks(1);
        check_lamps("ped_green_after", L_GREEN);
        check("ped_walk_green", {31'd0, ped_walk}, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
